// File: rtl/banco_pkg.sv
// Shared definitions for the parametrised register bank: state encoding,
// default widths and the preload formula used by the init sweep.
package banco_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Preload value of register i; callers truncate to their data width,
    // which gives the modulo 2**DATA_W behaviour for free.
    function automatic logic [63:0] preload_val(
        input int unsigned i,
        input int unsigned first = 5,
        input logic [63:0] base  = 64'd10,
        input logic [63:0] step  = 64'd5
    );
        if (i < first) begin
            return 64'd0;
        end
        return base + step * 64'(i - first);
    endfunction

endpackage

// File: rtl/banco_init_seq.sv
// Post-reset sequencer: sweeps every register with its preload value, then
// hands the bank over to normal service and flags writes dropped meanwhile.
module banco_init_seq
    import banco_pkg::*;
#(
    parameter int          DATA_W        = DATA_W_DEF,
    parameter int          ADDR_W        = ADDR_W_DEF,
    parameter int unsigned PRELOAD_FIRST = 5,
    parameter int unsigned PRELOAD_BASE  = 10,
    parameter int unsigned PRELOAD_STEP  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rwen,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              ready,
    output logic              listo,
    output logic              wr_desc
);

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              listo_reg;
    logic              wr_desc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= INIT;
            cnt_reg     <= '0;
            listo_reg   <= 1'b0;
            wr_desc_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    // Any write requested while sweeping is lost; report it.
                    wr_desc_reg <= rwen;
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (&cnt_reg) begin
                        state_reg <= READY;
                        listo_reg <= 1'b1;
                    end
                end
                READY: begin
                    wr_desc_reg <= 1'b0;
                    listo_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = (state_reg == READY);
    assign init_we   = (state_reg == INIT);
    assign init_addr = cnt_reg;
    assign init_data = DATA_W'(preload_val(32'(cnt_reg), PRELOAD_FIRST,
                                           64'(PRELOAD_BASE), 64'(PRELOAD_STEP)));
    assign listo     = listo_reg;
    assign wr_desc   = wr_desc_reg;

endmodule

// File: rtl/banco_registros_param.sv
// Multi-read, single-write register bank with same-cycle write bypass,
// optional hardwired-zero register 0 and a self-loading preload sweep.
module banco_registros_param
    import banco_pkg::*;
#(
    parameter int          DATA_W        = DATA_W_DEF,
    parameter int          ADDR_W        = ADDR_W_DEF,
    parameter int          NUM_RD        = 2,
    parameter bit          ZERO_REG      = 1'b1,
    parameter int unsigned PRELOAD_FIRST = 5,
    parameter int unsigned PRELOAD_BASE  = 10,
    parameter int unsigned PRELOAD_STEP  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RWEN,
    input  logic [ADDR_W-1:0]        DirWrite,
    input  logic [DATA_W-1:0]        DatoNuevo,
    input  logic [NUM_RD*ADDR_W-1:0] DirLect,
    output logic [NUM_RD*DATA_W-1:0] DatoLect,
    output logic                     listo,
    output logic                     wr_desc
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              user_wr_ok;

    banco_init_seq #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .PRELOAD_FIRST (PRELOAD_FIRST),
        .PRELOAD_BASE  (PRELOAD_BASE),
        .PRELOAD_STEP  (PRELOAD_STEP)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .rwen      (RWEN),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .ready     (ready),
        .listo     (listo),
        .wr_desc   (wr_desc)
    );

    // Writes to register 0 are swallowed when it is hardwired to zero.
    assign user_wr_ok = ready && RWEN && !(ZERO_REG && (DirWrite == '0));

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = DirWrite;
        wr_data = DatoNuevo;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_addr;
            wr_data = init_data;
        end else if (user_wr_ok) begin
            wr_en   = 1'b1;
        end
    end

    // Array has no reset: the sweep rewrites every entry after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            logic [DATA_W-1:0] rd_data;

            assign rd_addr = DirLect[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_data = mem[rd_addr];
                if (!ready) begin
                    rd_data = '0;
                end else if (ZERO_REG && (rd_addr == '0)) begin
                    rd_data = '0;
                end else if (RWEN && (rd_addr == DirWrite)) begin
                    rd_data = DatoNuevo;
                end
            end

            assign DatoLect[gi*DATA_W +: DATA_W] = rd_data;
        end
    endgenerate

endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
- Parametrised, clocked successor to the single-port combinational register bank.
- Provides NUM_RD independent combinational read ports and one clocked write port.
- Uses write-through bypass and an optional hardwired-zero register 0.
- After reset, a sequencer walks the whole array and writes the preload pattern, so no simulation-only initial block is needed. Sits between the control unit's RegWrite pipeline stage and the ALU operand fetch.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth is 2**ADDR_W.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 makes register 0 always read as 0 and discards writes to it.
- PRELOAD_FIRST, 5: first register that receives a non-zero preload value.
- PRELOAD_BASE, 10: preload value written to register PRELOAD_FIRST.
- PRELOAD_STEP, 5: preload increment per register above PRELOAD_FIRST.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- RWEN, input, 1: write enable.
- DirWrite, input, ADDR_W: write address.
- DatoNuevo, input, DATA_W: write data.
- DirLect, input, NUM_RD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- DatoLect, output, NUM_RD*DATA_W: read data; port k uses bits [k*DATA_W +: DATA_W]; combinational.
- listo, output, 1: high once the preload sweep is complete and the bank is in service.
- wr_desc, output, 1: one-cycle pulse when a write is dropped because the bank is still initialising.

Behaviour:
- Reset asserted, asynchronously:
  - state = INIT, init counter = 0, listo = 0, wr_desc = 0.
  - Array contents are not reset; the sweep rewrites them.
- State INIT, one register per clock:
  - Register i gets 0 if i < PRELOAD_FIRST, otherwise PRELOAD_BASE + PRELOAD_STEP*(i - PRELOAD_FIRST).
  - The result is truncated to DATA_W and computed modulo 2**DATA_W.
  - The counter increments each cycle. After writing index 2**ADDR_W - 1, the state moves to READY and listo rises on that same edge.
  - The sweep takes exactly 2**ADDR_W cycles after reset release.
- In INIT:
  - Every DatoLect port reads 0.
  - If RWEN = 1, the write is ignored and wr_desc = 1 on the next edge, for one cycle per dropped write.
- State READY:
  - On a rising edge with RWEN = 1, REG[DirWrite] <= DatoNuevo, except when ZERO_REG = 1 and DirWrite = 0, in which case the write is discarded.
  - wr_desc stays 0.
- Read path in READY, per port k:
  - If ZERO_REG = 1 and the address is 0, the port reads 0.
  - Otherwise, if RWEN = 1 and the address equals DirWrite, the port reads DatoNuevo (same-cycle bypass).
  - Otherwise the port reads REG[address].
- Multiple read ports may hit the same address, including the bypassed one; all return identical data.
- Back-to-back writes to the same address: the last write wins, and each is visible by bypass in its own cycle.
- Reset asserted mid-sweep or mid-operation: immediate return to INIT, and the sweep restarts at index 0.
- READY is terminal until the next reset.
- States are INIT and READY only; no illegal-state recovery beyond reset.

Decomposition:
- Shared package banco_pkg holds:
  - The state encoding (INIT = 1'b0, READY = 1'b1).
  - The preload formula as a constant function preload_val(i).
  - Default width constants DATA_W_DEF and ADDR_W_DEF.
- One sub-module, banco_init_seq, contains the INIT/READY FSM, the counter, the preload value generator, and the wr_desc pulse logic. It outputs init_we, init_addr and init_data, which are muxed onto the array write port.
- The read mux and bypass are instantiated per port via a generate loop in the top.

Test Plan:
- Sweep timing and reads during INIT: release reset and count cycles -> listo rises exactly 32 edges later; DatoLect = 0 on all ports throughout.
- Preload values: after listo, read addresses 5/6/31 -> 10/15/140; read addresses 0/4 -> 0.
- Write in READY: RWEN = 1, DirWrite = 7, DatoNuevo = 0xDEADBEEF, with both ports reading 7 -> 0xDEADBEEF in the same cycle (bypass) and in the following cycle with RWEN = 0.
- Register 0 protection: write 0x1234 to address 0 -> reads 0 in the same and next cycle with ZERO_REG = 1. With ZERO_REG = 0 -> reads 0x1234 on the next cycle.
- Dropped write: RWEN = 1 at sweep cycle 3 (DirWrite = 9, DatoNuevo = 99) -> wr_desc pulses for one cycle; after listo, address 9 reads 30.
- Reset mid-operation: write 77 to address 12, then assert rst for 2 cycles -> listo drops immediately; after the 32-cycle sweep, address 12 reads 45.
